mario_motion: RTL and testbench



---
 rtl/mario_pkg.sv | 43 ++++
 rtl/mario_gravity.sv | 80 ++++++++
 rtl/mario_motion.sv | 223 ++++++++++++++++++++++
 tb/tb_mario_motion.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mario_pkg.sv
// Shared types and default physics constants for the player-motion controller.
package mario_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2,
        DEAD   = 2'd3
    } motion_state_t;

    // How the velocity/gravity unit updates on the coming edge.
    typedef enum logic [1:0] {
        G_CLEAR = 2'd0,
        G_JUMP  = 2'd1,
        G_STOP  = 2'd2,
        G_RUN   = 2'd3
    } grav_mode_t;

    localparam logic [7:0] KEYC_LEFT  = 8'h04;
    localparam logic [7:0] KEYC_RIGHT = 8'h07;
    localparam logic [7:0] KEYC_JUMP  = 8'h1A;

    localparam int DEF_POS_W          = 10;
    localparam int DEF_V_W            = 6;
    localparam int DEF_SIZE           = 16;
    localparam int DEF_X_START        = 464;
    localparam int DEF_Y_START        = 50;
    localparam int DEF_X_MAX          = 639;
    localparam int DEF_WALK_SPEED     = 2;
    localparam int DEF_JUMP_V         = 9;
    localparam int DEF_JUMP_CUT       = 3;
    localparam int DEF_GRAV_DIV       = 6;
    localparam int DEF_TERMINAL_V     = 4;
    localparam int DEF_Y_KILL         = 480;
    localparam int DEF_RESPAWN_X      = 50;
    localparam int DEF_RESPAWN_Y      = 50;
    localparam int DEF_RESPAWN_FRAMES = 60;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mario_gravity.sv
// Vertical velocity register with divided gravity, terminal clamp and jump cut.
module mario_gravity
    import mario_pkg::*;
#(
    parameter int V_W        = DEF_V_W,
    parameter int GRAV_DIV   = DEF_GRAV_DIV,
    parameter int TERMINAL_V = DEF_TERMINAL_V,
    parameter int JUMP_V     = DEF_JUMP_V,
    parameter int JUMP_CUT   = DEF_JUMP_CUT
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    input  grav_mode_t            i_mode,
    input  logic                  i_cut,
    output logic signed [V_W-1:0] o_vel_y,
    output logic                  o_run_nonneg
);

    localparam int C_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam logic signed [V_W-1:0] VEL_TERM = V_W'(TERMINAL_V);
    localparam logic signed [V_W-1:0] VEL_JUMP = V_W'(-JUMP_V);
    localparam logic signed [V_W-1:0] VEL_CUT  = V_W'(-JUMP_CUT);
    localparam logic signed [V_W-1:0] VEL_ONE  = V_W'(1);

    logic [C_W-1:0]        r_cnt;
    logic signed [V_W-1:0] r_vel;
    logic                  w_wrap;
    logic [C_W-1:0]        w_cnt_adv;
    logic signed [V_W-1:0] w_vel_cut;
    logic signed [V_W-1:0] w_vel_run;

    assign w_wrap       = (r_cnt == C_W'(GRAV_DIV - 1));
    assign w_cnt_adv    = w_wrap ? '0 : r_cnt + C_W'(1);
    assign o_vel_y      = r_vel;
    assign o_run_nonneg = ~w_vel_run[V_W-1];

    // Velocity a free-flight frame would produce: cut first, then gravity on wrap.
    always_comb begin
        w_vel_cut = r_vel;
        w_vel_run = r_vel;
        if (i_cut && (r_vel < VEL_CUT)) begin
            w_vel_cut = VEL_CUT;
        end else begin
            w_vel_cut = r_vel;
        end
        if (w_wrap) begin
            w_vel_run = (w_vel_cut >= VEL_TERM) ? VEL_TERM : w_vel_cut + VEL_ONE;
        end else begin
            w_vel_run = w_vel_cut;
        end
    end

    // Gravity divider and velocity register.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_cnt <= '0;
            r_vel <= '0;
        end else begin
            case (i_mode)
                G_JUMP: begin
                    r_cnt <= '0;
                    r_vel <= VEL_JUMP;
                end
                G_STOP: begin
                    r_cnt <= w_cnt_adv;
                    r_vel <= '0;
                end
                G_RUN: begin
                    r_cnt <= w_cnt_adv;
                    r_vel <= w_vel_run;
                end
                default: begin
                    r_cnt <= '0;
                    r_vel <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mario_motion.sv
// Per-frame player motion: ground/rise/fall/dead FSM with clamped position,
// surface snapping, kill line and timed respawn.
module mario_motion
    import mario_pkg::*;
#(
    parameter int         POS_W          = DEF_POS_W,
    parameter int         V_W            = DEF_V_W,
    parameter int         SIZE           = DEF_SIZE,
    parameter int         X_START        = DEF_X_START,
    parameter int         Y_START        = DEF_Y_START,
    parameter int         X_MAX          = DEF_X_MAX,
    parameter int         WALK_SPEED     = DEF_WALK_SPEED,
    parameter int         JUMP_V         = DEF_JUMP_V,
    parameter int         JUMP_CUT       = DEF_JUMP_CUT,
    parameter int         GRAV_DIV       = DEF_GRAV_DIV,
    parameter int         TERMINAL_V     = DEF_TERMINAL_V,
    parameter int         Y_KILL         = DEF_Y_KILL,
    parameter int         RESPAWN_X      = DEF_RESPAWN_X,
    parameter int         RESPAWN_Y      = DEF_RESPAWN_Y,
    parameter int         RESPAWN_FRAMES = DEF_RESPAWN_FRAMES,
    parameter logic [7:0] KEY_LEFT       = KEYC_LEFT,
    parameter logic [7:0] KEY_RIGHT      = KEYC_RIGHT,
    parameter logic [7:0] KEY_JUMP       = KEYC_JUMP
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    input  logic [7:0]            keycode,
    input  logic                  hit_up,
    input  logic                  hit_down,
    input  logic                  hit_left,
    input  logic                  hit_right,
    input  logic [POS_W-1:0]      floor_y,
    output logic [POS_W-1:0]      pos_x,
    output logic [POS_W-1:0]      pos_y,
    output logic signed [V_W-1:0] vel_y,
    output logic [1:0]            state,
    output logic                  facing_left,
    output logic                  dead,
    output logic [7:0]            death_count
);

    localparam int S_W = POS_W + 1;
    localparam int T_W = (RESPAWN_FRAMES > 2) ? $clog2(RESPAWN_FRAMES) : 1;
    localparam logic [POS_W-1:0]        X_LIM   = POS_W'(X_MAX - SIZE + 1);
    localparam logic [POS_W:0]          X_LIM_W = (POS_W + 1)'(X_MAX - SIZE + 1);
    localparam logic [POS_W-1:0]        WALK    = POS_W'(WALK_SPEED);
    localparam logic [POS_W-1:0]        KILL_Y  = POS_W'(Y_KILL);
    localparam logic signed [S_W-1:0]   SIZE_S  = S_W'(SIZE);

    motion_state_t         r_state;
    logic [POS_W-1:0]      r_pos_x;
    logic [POS_W-1:0]      r_pos_y;
    logic                  r_facing;
    logic                  r_dead;
    logic [7:0]            r_death_count;
    logic [T_W-1:0]        r_timer;
    logic                  r_jump_prev;

    logic                  w_jump_pressed;
    logic                  w_kill;
    logic                  w_run_nonneg;
    logic                  w_cut;
    grav_mode_t            w_mode;
    grav_mode_t            w_grav_mode;
    motion_state_t         w_state_nxt;
    logic [POS_W-1:0]      w_pos_y_nxt;
    logic [POS_W-1:0]      w_pos_x_nxt;
    logic                  w_facing_nxt;
    logic signed [S_W-1:0] w_y_move;
    logic signed [S_W-1:0] w_y_snap;
    logic [POS_W:0]        w_x_add;

    assign w_jump_pressed = (keycode == KEY_JUMP) && !r_jump_prev;
    assign w_kill         = (r_state != DEAD) && (r_pos_y > KILL_Y);
    assign w_y_move       = $signed({1'b0, r_pos_y}) + S_W'(vel_y);
    assign w_y_snap       = $signed({1'b0, floor_y}) - SIZE_S;
    assign w_x_add        = {1'b0, r_pos_x} + {1'b0, WALK};
    assign w_grav_mode    = (w_kill || (r_state == DEAD)) ? G_CLEAR : w_mode;

    mario_gravity #(
        .V_W        (V_W),
        .GRAV_DIV   (GRAV_DIV),
        .TERMINAL_V (TERMINAL_V),
        .JUMP_V     (JUMP_V),
        .JUMP_CUT   (JUMP_CUT)
    ) u_gravity (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .i_mode       (w_grav_mode),
        .i_cut        (w_cut),
        .o_vel_y      (vel_y),
        .o_run_nonneg (w_run_nonneg)
    );

    // Vertical next-state; any negative row clamps to 0 and drops into FALL.
    always_comb begin
        w_state_nxt = r_state;
        w_pos_y_nxt = r_pos_y;
        w_mode      = G_CLEAR;
        w_cut       = 1'b0;
        case (r_state)
            GROUND: begin
                if (w_jump_pressed) begin
                    w_state_nxt = RISE;
                    w_mode      = G_JUMP;
                end else if (!hit_down) begin
                    w_state_nxt = FALL;
                end else begin
                    w_state_nxt = GROUND;
                end
            end
            RISE: begin
                w_cut = (keycode != KEY_JUMP);
                if (w_y_move[S_W-1]) begin
                    w_pos_y_nxt = '0;
                    w_mode      = G_STOP;
                    w_state_nxt = FALL;
                end else begin
                    w_pos_y_nxt = w_y_move[POS_W-1:0];
                    if (hit_up) begin
                        w_mode      = G_STOP;
                        w_state_nxt = FALL;
                    end else begin
                        w_mode      = G_RUN;
                        w_state_nxt = w_run_nonneg ? FALL : RISE;
                    end
                end
            end
            FALL: begin
                if (hit_down && !vel_y[V_W-1]) begin
                    if (w_y_snap[S_W-1]) begin
                        w_pos_y_nxt = '0;
                        w_mode      = G_STOP;
                        w_state_nxt = FALL;
                    end else begin
                        w_pos_y_nxt = w_y_snap[POS_W-1:0];
                        w_mode      = G_CLEAR;
                        w_state_nxt = GROUND;
                    end
                end else if (w_y_move[S_W-1]) begin
                    w_pos_y_nxt = '0;
                    w_mode      = G_STOP;
                    w_state_nxt = FALL;
                end else begin
                    w_pos_y_nxt = w_y_move[POS_W-1:0];
                    w_mode      = G_RUN;
                    w_state_nxt = FALL;
                end
            end
            default: begin
                w_mode = G_CLEAR;
            end
        endcase
    end

    // Horizontal walk with screen clamps; a blocked key still turns the sprite.
    always_comb begin
        w_pos_x_nxt  = r_pos_x;
        w_facing_nxt = r_facing;
        if (keycode == KEY_LEFT) begin
            w_facing_nxt = 1'b1;
            if (!hit_left) begin
                w_pos_x_nxt = (r_pos_x >= WALK) ? r_pos_x - WALK : '0;
            end else begin
                w_pos_x_nxt = r_pos_x;
            end
        end else if (keycode == KEY_RIGHT) begin
            w_facing_nxt = 1'b0;
            if (!hit_right) begin
                w_pos_x_nxt = (w_x_add > X_LIM_W) ? X_LIM : w_x_add[POS_W-1:0];
            end else begin
                w_pos_x_nxt = r_pos_x;
            end
        end else begin
            w_pos_x_nxt  = r_pos_x;
            w_facing_nxt = r_facing;
        end
    end

    // Motion FSM and registered outputs: dead handling, then kill, then normal motion.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state       <= FALL;
            r_pos_x       <= POS_W'(X_START);
            r_pos_y       <= POS_W'(Y_START);
            r_facing      <= 1'b0;
            r_dead        <= 1'b0;
            r_death_count <= 8'd0;
            r_timer       <= '0;
            r_jump_prev   <= 1'b0;
        end else begin
            r_jump_prev <= (keycode == KEY_JUMP);
            if (r_state == DEAD) begin
                if (r_timer == '0) begin
                    r_state <= FALL;
                    r_pos_x <= POS_W'(RESPAWN_X);
                    r_pos_y <= POS_W'(RESPAWN_Y);
                    r_dead  <= 1'b0;
                end else begin
                    r_timer <= r_timer - T_W'(1);
                end
            end else if (w_kill) begin
                r_state       <= DEAD;
                r_dead        <= 1'b1;
                r_timer       <= T_W'(RESPAWN_FRAMES - 1);
                r_death_count <= sat_inc8(r_death_count);
            end else begin
                r_state  <= w_state_nxt;
                r_pos_y  <= w_pos_y_nxt;
                r_pos_x  <= w_pos_x_nxt;
                r_facing <= w_facing_nxt;
            end
        end
    end

    assign pos_x       = r_pos_x;
    assign pos_y       = r_pos_y;
    assign state       = r_state;
    assign facing_left = r_facing;
    assign dead        = r_dead;
    assign death_count = r_death_count;

endmodule

// File: tb/tb_mario_motion.sv
// Directed bench for mario_motion: fall, land, jump, walk clamps, death/respawn, reset.
module tb_mario_motion;

    logic              clk;
    logic              Reset;
    logic [7:0]        keycode;
    logic              hit_up, hit_down, hit_left, hit_right;
    logic [9:0]        floor_y;
    logic [9:0]        pos_x, pos_y;
    logic signed [5:0] vel_y;
    logic [1:0]        state;
    logic              facing_left, dead;
    logic [7:0]        death_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_dead;

    mario_motion dut (
        .frame_clk   (clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .hit_up      (hit_up),
        .hit_down    (hit_down),
        .hit_left    (hit_left),
        .hit_right   (hit_right),
        .floor_y     (floor_y),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .vel_y       (vel_y),
        .state       (state),
        .facing_left (facing_left),
        .dead        (dead),
        .death_count (death_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_pos_x"}, int'(pos_x), 464);
        check_eq({tag, "_pos_y"}, int'(pos_y), 50);
        check_eq({tag, "_vel"},   int'(vel_y), 0);
        check_eq({tag, "_state"}, int'(state), 2);
        check_eq({tag, "_face"},  int'(facing_left), 0);
        check_eq({tag, "_dead"},  int'(dead), 0);
        check_eq({tag, "_dcnt"},  int'(death_count), 0);
    endtask

    initial begin
        Reset = 1'b1; keycode = 8'h00; floor_y = 10'd0;
        hit_up = 1'b0; hit_down = 1'b0; hit_left = 1'b0; hit_right = 1'b0;
        step();
        Reset = 1'b0;
        check_reset_vals("rst");

        // Free fall from reset: gravity every 6th frame.
        for (int e = 1; e <= 12; e++) begin
            step();
            check_eq("fall_state", int'(state), 2);
            if (e <= 6) check_eq("fall_y_hold", int'(pos_y), 50);
            if (e == 6) check_eq("fall_vel6", int'(vel_y), 1);
            if (e == 7) check_eq("fall_y7", int'(pos_y), 51);
            if (e == 12) begin
                check_eq("fall_vel12", int'(vel_y), 2);
                check_eq("fall_y12", int'(pos_y), 56);
            end
        end

        // Land on floor 400.
        hit_down = 1'b1; floor_y = 10'd400;
        step();
        check_eq("land_y", int'(pos_y), 384);
        check_eq("land_vel", int'(vel_y), 0);
        check_eq("land_state", int'(state), 0);

        // Jump and hold.
        keycode = 8'h1A;
        step();
        check_eq("jump_state", int'(state), 1);
        check_eq("jump_vel", int'(vel_y), -9);
        check_eq("jump_y", int'(pos_y), 384);
        hit_down = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step();
            check_eq("rise_y", int'(pos_y), 384 - 9 * e);
        end
        check_eq("rise_vel8", int'(vel_y), -8);
        check_eq("rise_state", int'(state), 1);

        // Release: velocity cut to -3.
        keycode = 8'h00;
        step();
        check_eq("cut_vel", int'(vel_y), -3);
        check_eq("cut_y", int'(pos_y), 322);
        check_eq("cut_state", int'(state), 1);

        // Ceiling hit ends the rise.
        keycode = 8'h1A; hit_up = 1'b1;
        step();
        check_eq("ceil_y", int'(pos_y), 319);
        check_eq("ceil_vel", int'(vel_y), 0);
        check_eq("ceil_state", int'(state), 2);

        // Land with jump still held, then no re-jump.
        hit_up = 1'b0; hit_down = 1'b1;
        step();
        check_eq("reland_y", int'(pos_y), 384);
        check_eq("reland_state", int'(state), 0);
        step();
        check_eq("nojump_state", int'(state), 0);
        check_eq("nojump_vel", int'(vel_y), 0);

        // Walk right to the clamp.
        keycode = 8'h07;
        repeat (79) step();
        check_eq("walk_x622", int'(pos_x), 622);
        check_eq("walk_face", int'(facing_left), 0);
        step();
        check_eq("walk_x624", int'(pos_x), 624);
        step();
        check_eq("walk_clampR", int'(pos_x), 624);

        // Blocked left still turns; then walk left to 0.
        keycode = 8'h04; hit_left = 1'b1;
        step();
        check_eq("blk_x", int'(pos_x), 624);
        check_eq("blk_face", int'(facing_left), 1);
        hit_left = 1'b0;
        step();
        check_eq("left_x", int'(pos_x), 622);
        repeat (311) step();
        check_eq("left_x0", int'(pos_x), 0);
        step();
        check_eq("left_clampL", int'(pos_x), 0);

        // Walk off a ledge.
        keycode = 8'h00; hit_down = 1'b0;
        step();
        check_eq("ledge_state", int'(state), 2);
        check_eq("ledge_vel", int'(vel_y), 0);
        check_eq("ledge_y", int'(pos_y), 384);

        // Snap just past the kill line, then die.
        hit_down = 1'b1; floor_y = 10'd497;
        step();
        check_eq("snap481_y", int'(pos_y), 481);
        check_eq("snap481_state", int'(state), 0);
        hit_down = 1'b0; keycode = 8'h07;
        step();
        check_eq("kill_dead", int'(dead), 1);
        check_eq("kill_state", int'(state), 3);
        check_eq("kill_dcnt", int'(death_count), 1);
        check_eq("kill_x_frozen", int'(pos_x), 0);
        check_eq("kill_y_frozen", int'(pos_y), 481);
        n_dead = 1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!dead) break;
            n_dead++;
        end
        check_eq("dead_edges", n_dead, 60);
        check_eq("resp_x", int'(pos_x), 50);
        check_eq("resp_y", int'(pos_y), 50);
        check_eq("resp_state", int'(state), 2);
        check_eq("resp_vel", int'(vel_y), 0);
        check_eq("resp_dcnt", int'(death_count), 1);

        // Die again and reset mid-DEAD.
        keycode = 8'h00; hit_down = 1'b1; floor_y = 10'd497;
        step();
        check_eq("snap2_y", int'(pos_y), 481);
        hit_down = 1'b0;
        step();
        check_eq("kill2_dcnt", int'(death_count), 2);
        check_eq("kill2_dead", int'(dead), 1);
        repeat (10) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_reset_vals("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
